// File: rtl/peb_datamux_if.sv
// CPU-side word-access handshake and PEB byte-bus signal bundles used by peb_datamux.
// Signal names match the original flat port list so existing connections map one-to-one.
interface peb_cpu_if;
  logic [0:14] cpu_a;
  logic [0:15] cpu_d;
  logic        cpu_we;
  logic        cpu_req;
  logic [0:15] cpu_q;
  logic        cpu_ack;
  logic        cpu_err;
  logic        busy;

  modport master (
    output cpu_a, cpu_d, cpu_we, cpu_req,
    input  cpu_q, cpu_ack, cpu_err, busy
  );

  modport slave (
    input  cpu_a, cpu_d, cpu_we, cpu_req,
    output cpu_q, cpu_ack, cpu_err, busy
  );
endinterface

interface peb_bus_if;
  logic [0:15] a;
  logic [0:7]  d;
  logic [0:7]  q;
  logic        q_select;
  logic        memen;
  logic        we;
  logic        ready;

  modport master (
    output a, d, memen, we,
    input  q, q_select, ready
  );

  modport slave (
    input  a, d, memen, we,
    output q, q_select, ready
  );
endinterface

// File: rtl/peb_datamux.sv
// PEB bus initiator: splits each 16-bit CPU word access into two 8-bit PEB
// memory cycles (odd byte first), with optional per-strobe not-ready timeout.
module peb_datamux #(
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned TW      = 8
) (
  input  logic       clk,
  input  logic       reset,
  peb_cpu_if.slave   cpu,
  peb_bus_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ODD,
    S_ODD_CAP,
    S_EVEN,
    S_EVEN_CAP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [0:14]   addr_q, addr_d;
  logic [0:15]   wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          err_q, err_d;
  logic          byte_to_q, byte_to_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [0:7]    lo_q, lo_d;
  logic [0:15]   a_q, a_d;
  logic [0:7]    d_q, d_d;
  logic          memen_q, memen_d;
  logic          we_q, we_d;
  logic [0:15]   cpu_q_q, cpu_q_d;

  logic          timeout_hit;
  logic          strobe_end;
  logic [0:7]    cap_byte;

  // A timed-out strobe ends exactly like a ready one; a zero TIMEOUT never fires.
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && !bus.ready && (cnt_q == TW'(TIMEOUT));
    strobe_end  = bus.ready || timeout_hit;
    cap_byte    = (bus.q_select && !byte_to_q) ? bus.q : 8'hFF;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    err_d     = err_q;
    byte_to_d = byte_to_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    a_d       = a_q;
    d_d       = d_q;
    memen_d   = memen_q;
    we_d      = we_q;
    cpu_q_d   = cpu_q_q;

    unique case (state_q)
      S_IDLE: begin
        memen_d = 1'b0;
        if (cpu.cpu_req) begin
          // Strobe outputs come straight from the CPU inputs so the odd cycle
          // is on the bus in the first cycle after acceptance.
          state_d = S_ODD;
          addr_d  = cpu.cpu_a;
          wdata_d = cpu.cpu_d;
          rd_d    = !cpu.cpu_we;
          err_d   = 1'b0;
          cnt_d   = '0;
          a_d     = {cpu.cpu_a, 1'b1};
          d_d     = cpu.cpu_d[8:15];
          we_d    = cpu.cpu_we;
          memen_d = 1'b1;
        end
      end

      S_ODD: begin
        if (strobe_end) begin
          byte_to_d = timeout_hit;
          err_d     = err_q || timeout_hit;
          if (rd_q) begin
            state_d = S_ODD_CAP;
            memen_d = 1'b0;
          end else begin
            state_d = S_EVEN;
            cnt_d   = '0;
            a_d     = {addr_q, 1'b0};
            d_d     = wdata_q[0:7];
            memen_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ODD_CAP: begin
        lo_d    = cap_byte;
        state_d = S_EVEN;
        cnt_d   = '0;
        a_d     = {addr_q, 1'b0};
        d_d     = wdata_q[0:7];
        memen_d = 1'b1;
      end

      S_EVEN: begin
        if (strobe_end) begin
          byte_to_d = timeout_hit;
          err_d     = err_q || timeout_hit;
          memen_d   = 1'b0;
          state_d   = rd_q ? S_EVEN_CAP : S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_EVEN_CAP: begin
        cpu_q_d = {cap_byte, lo_q};
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        memen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
      byte_to_q <= 1'b0;
      cnt_q     <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      d_q       <= '0;
      memen_q   <= 1'b0;
      we_q      <= 1'b0;
      cpu_q_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      byte_to_q <= byte_to_d;
      cnt_q     <= cnt_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      d_q       <= d_d;
      memen_q   <= memen_d;
      we_q      <= we_d;
      cpu_q_q   <= cpu_q_d;
    end
  end

  assign bus.a       = a_q;
  assign bus.d       = d_q;
  assign bus.memen   = memen_q;
  assign bus.we      = we_q;
  assign cpu.cpu_q   = cpu_q_q;
  assign cpu.cpu_ack = (state_q == S_DONE);
  assign cpu.cpu_err = (state_q == S_DONE) && err_q;
  assign cpu.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_peb_datamux.sv
// Bench for peb_datamux: a 32K RAM card model on the upper half of the PEB,
// directed vectors from a table, a reset-abort sequence, then random accesses.
module tb_peb_datamux;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  peb_cpu_if cpu();
  peb_bus_if bus();

  peb_datamux #(.TIMEOUT(TO), .TW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (cpu),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Card: synchronous RAM claiming 0x8000-0xFFFF, read data valid one cycle later.
  logic [7:0]  cmem [0:32767];
  logic [7:0]  rdata = 8'h00;
  logic [7:0]  junk  = 8'h00;
  logic [15:0] card_a;
  assign card_a       = bus.a;
  assign bus.q_select = card_a[15];
  assign bus.q        = bus.q_select ? rdata : junk;

  initial begin : card
    for (int i = 0; i < 32768; i++) cmem[i] = 8'h00;
    forever begin
      @(posedge clk);
      junk <= 8'($urandom);
      if (bus.memen && bus.ready && card_a[15]) begin
        if (bus.we) cmem[card_a[14:0]] <= bus.d;
        else        rdata <= cmem[card_a[14:0]];
      end
    end
  end

  // Reference model: byte-addressed memory image plus last word read.
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] model_q;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_access(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                              input int n_odd, input int n_even,
                              output logic [15:0] mq, output logic merr, output int mack);
    logic        to_o, to_e, sel;
    logic [15:0] odd_a, even_a;
    to_o   = n_odd > int'(TO);
    to_e   = n_even > int'(TO);
    sel    = addr[15];
    odd_a  = {addr[15:1], 1'b1};
    even_a = {addr[15:1], 1'b0};
    if (wr) begin
      if (sel && !to_o) ref_mem[odd_a]  = data[7:0];
      if (sel && !to_e) ref_mem[even_a] = data[15:8];
    end else begin
      model_q = {(sel && !to_e) ? ref_mem[even_a] : 8'hFF,
                 (sel && !to_o) ? ref_mem[odd_a]  : 8'hFF};
    end
    mq   = model_q;
    merr = to_o || to_e;
    mack = (to_o ? int'(TO) : n_odd) + 1 + (to_e ? int'(TO) : n_even) + 1 + (wr ? 0 : 2) + 1;
  endtask

  // Called just after a negedge; request is accepted at the next posedge (E0).
  task automatic do_access(input string tag, input logic wr, input logic [15:0] addr,
                           input logic [15:0] data, input int n_odd, input int n_even,
                           input logic [15:0] exp_q, input logic exp_err, input int exp_ack);
    int          odd_seen, even_seen, odd_len, even_len;
    logic        got_ack;
    logic [15:0] ba;
    odd_len  = ((n_odd > int'(TO)) ? int'(TO) : n_odd) + 1;
    even_len = ((n_even > int'(TO)) ? int'(TO) : n_even) + 1;
    odd_seen = 0;
    even_seen = 0;
    got_ack  = 1'b0;
    cpu.cpu_a   = addr[15:1];
    cpu.cpu_d   = data;
    cpu.cpu_we  = wr;
    cpu.cpu_req = 1'b1;
    for (int c = 1; c <= 60 && !got_ack; c++) begin
      @(negedge clk);
      if (bus.memen) begin
        ba = bus.a;
        if (ba[0]) begin
          check({tag, "/odd_a"}, ba, {addr[15:1], 1'b1});
          check({tag, "/odd_d"}, bus.d, data[7:0]);
          check({tag, "/odd_we"}, bus.we, wr);
          bus.ready = (odd_seen >= n_odd);
          odd_seen++;
        end else begin
          if (even_seen == 0) check({tag, "/odd_first"}, odd_seen, odd_len);
          check({tag, "/even_a"}, ba, {addr[15:1], 1'b0});
          check({tag, "/even_d"}, bus.d, data[15:8]);
          check({tag, "/even_we"}, bus.we, wr);
          bus.ready = (even_seen >= n_even);
          even_seen++;
        end
      end else begin
        bus.ready = 1'($urandom);
      end
      if (cpu.cpu_ack) begin
        got_ack = 1'b1;
        cpu.cpu_req = 1'b0;
        check({tag, "/ack_cycle"}, c, exp_ack);
        check({tag, "/cpu_q"}, cpu.cpu_q, exp_q);
        check({tag, "/cpu_err"}, cpu.cpu_err, exp_err);
      end else begin
        check({tag, "/busy"}, cpu.busy, 1'b1);
        check({tag, "/err_noack"}, cpu.cpu_err, 1'b0);
      end
    end
    if (!got_ack) begin
      check({tag, "/ack_seen"}, 0, 1);
      cpu.cpu_req = 1'b0;
    end
    check({tag, "/odd_len"}, odd_seen, odd_len);
    check({tag, "/even_len"}, even_seen, even_len);
    @(negedge clk);
    check({tag, "/gap_busy"}, cpu.busy, 1'b0);
    check({tag, "/gap_ack"}, cpu.cpu_ack, 1'b0);
  endtask

  typedef struct {
    string       tag;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          n_odd;
    int          n_even;
    logic [15:0] exp_q;
    logic        exp_err;
    int          exp_ack;
  } vec_t;

  vec_t vecs [9];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] mq;
    logic        merr;
    int          mack;
    logic        wr;
    logic [15:0] addr, data;
    int          no, ne;

    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    model_q = 16'h0000;

    vecs[0] = '{"wr_a000",   1'b1, 16'hA000, 16'h1234, 0, 0, 16'h0000, 1'b0, 3};
    vecs[1] = '{"rd_a000",   1'b0, 16'hA000, 16'h0F0F, 0, 0, 16'h1234, 1'b0, 5};
    vecs[2] = '{"rd_nocard", 1'b0, 16'h4000, 16'h0000, 0, 0, 16'hFFFF, 1'b0, 5};
    vecs[3] = '{"rd_stall3", 1'b0, 16'hA000, 16'hC3C3, 3, 0, 16'h1234, 1'b0, 8};
    vecs[4] = '{"rd_tmo",    1'b0, 16'h2000, 16'h0000, 9, 9, 16'hFFFF, 1'b1, 13};
    vecs[5] = '{"wr_edge4",  1'b1, 16'hA002, 16'hBEEF, 0, 4, 16'hFFFF, 1'b0, 7};
    vecs[6] = '{"rd_a002",   1'b0, 16'hA002, 16'h0000, 0, 0, 16'hBEEF, 1'b0, 5};
    vecs[7] = '{"wr_oddtmo", 1'b1, 16'h8000, 16'h55AA, 7, 0, 16'hBEEF, 1'b1, 7};
    vecs[8] = '{"rd_8000",   1'b0, 16'h8000, 16'h0000, 0, 0, 16'h5500, 1'b0, 5};

    cpu.cpu_a = '0;
    cpu.cpu_d = '0;
    cpu.cpu_we = 1'b0;
    cpu.cpu_req = 1'b0;
    bus.ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a", bus.a, 16'h0000);
    check("rst_d", bus.d, 8'h00);
    check("rst_memen", bus.memen, 1'b0);
    check("rst_we", bus.we, 1'b0);
    check("rst_cpu_q", cpu.cpu_q, 16'h0000);
    check("rst_ack", cpu.cpu_ack, 1'b0);
    check("rst_err", cpu.cpu_err, 1'b0);
    check("rst_busy", cpu.busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      model_access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].n_odd, vecs[i].n_even,
                   mq, merr, mack);
      do_access(vecs[i].tag, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].n_odd,
                vecs[i].n_even, vecs[i].exp_q, vecs[i].exp_err, vecs[i].exp_ack);
    end

    // Reset while the even strobe of a write is stalled.
    cpu.cpu_a = 15'h5002;
    cpu.cpu_d = 16'h7777;
    cpu.cpu_we = 1'b1;
    cpu.cpu_req = 1'b1;
    @(negedge clk);
    check("rstw_c1_memen", bus.memen, 1'b1);
    check("rstw_c1_a", bus.a, 16'hA005);
    bus.ready = 1'b1;
    @(negedge clk);
    check("rstw_c2_memen", bus.memen, 1'b1);
    check("rstw_c2_a", bus.a, 16'hA004);
    bus.ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rstw_memen", bus.memen, 1'b0);
    check("rstw_busy", cpu.busy, 1'b0);
    check("rstw_a", bus.a, 16'h0000);
    check("rstw_ack", cpu.cpu_ack, 1'b0);
    cpu.cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw_hold_ack", cpu.cpu_ack, 1'b0);
    end
    reset = 1'b0;
    bus.ready = 1'b1;
    ref_mem[16'hA005] = 8'h77;
    model_q = 16'h0000;
    @(negedge clk);
    check("rstw_idle_ack", cpu.cpu_ack, 1'b0);
    model_access(1'b0, 16'hA004, 16'h0000, 0, 0, mq, merr, mack);
    do_access("rd_after_rst", 1'b0, 16'hA004, 16'h0000, 0, 0, mq, merr, mack);

    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom);
      addr = {($urandom_range(0, 3) != 0), 10'h000, 4'($urandom), 1'b0};
      data = 16'($urandom);
      no   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      ne   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      model_access(wr, addr, data, no, ne, mq, merr, mack);
      do_access("rand", wr, addr, data, no, ne, mq, merr, mack);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
